pc_predict: RTL
===============

# pc_predict

Parametrised fetch program-counter generator with an optional branch target buffer (BTB). Each cycle it presents the fetch address to IF together with a next-PC prediction. It advances sequentially, or to a predicted target when the BTB hits and predicts taken. On a misprediction it accepts a redirect from EX, and EX trains it through an update port. It replaces the fixed-step, jump-only PC register at the head of the pipeline.

## Interface
Parameters:
- ADDR_W, 32, address width in bits.
- BTB_DEPTH, 16, number of BTB entries; a power of 2, at least 2.
- RESET_PC, 32'h0, value loaded into pc_out on reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset, asynchronous and active-high.
- rdy_in  input  1  global enable; when 0, no state changes anywhere in the block.
- stall_in  input  1  fetch stall; 1 holds pc_out.
- redirect_in  input  1  EX misprediction or jump redirect.
- redirect_target_in  input  ADDR_W  correct next fetch address.
- update_valid_in  input  1  BTB training strobe from EX.
- update_pc_in  input  ADDR_W  address of the resolved branch.
- update_target_in  input  ADDR_W  resolved target.
- update_taken_in  input  1  resolved direction.
- pc_out  output  ADDR_W  current fetch address (register).
- pred_taken_out  output  1  prediction for pc_out; combinational from pc_out and BTB state.
- pred_target_out  output  ADDR_W  predicted next address for pc_out; equals pc_out+PC_STEP when not taken.

## Operation
- Index width is IW = log2(BTB_DEPTH).
- Index = pc[IW+1:2]. Tag = pc[ADDR_W-1:IW+2].
- Each BTB entry holds: valid, tag, target (ADDR_W bits), and a 2-bit counter.
- Counter encoding: 00 strong not-taken, 01 weak not-taken, 10 weak taken, 11 strong taken.
- Lookup on pc_out:
  - Hit = valid and tag match.
  - pred_taken_out = hit & ctr[1].
  - pred_target_out = pred_taken_out ? target : pc_out+PC_STEP.
- Next pc_out, evaluated only when rdy_in=1, in priority order:
  1. redirect_in=1 → redirect_target_in. Applies even when stall_in=1.
  2. stall_in=1 → hold.
  3. Otherwise → pred_target_out.
- Update, when rdy_in=1 and update_valid_in=1; independent of stall_in and redirect_in:
  - Hit on update_pc_in: counter saturating-increments if taken, saturating-decrements if not. If taken, target is overwritten with update_target_in.
  - Miss and taken: allocate the entry. Set valid=1, write tag and target, set ctr=10. Any previous occupant is evicted.
  - Miss and not taken: no change.
- Same-cycle lookup and update of the same entry: the lookup sees the pre-update contents (read-before-write). The new state is visible next cycle.
- Arithmetic: pc_out+PC_STEP wraps modulo 2^ADDR_W with no overflow flag. Address bits [1:0] are not used for indexing or tagging.

## Timing
- Reset (asynchronous, immediate):
  - pc_out = RESET_PC.
  - All valid bits = 0 and all counters = 00.
  - Outputs therefore read pred_taken_out=0 and pred_target_out=RESET_PC+PC_STEP.
- Redirect: one-cycle latency. redirect_in sampled at edge N gives pc_out = target after edge N.
- Update: one-cycle latency. It affects prediction from the cycle after the update edge.
- Predictions are zero-latency: the pred outputs are valid in the same cycle as pc_out.
- Reset asserted mid-operation discards any pending redirect or update. The first edge after deassertion advances normally from RESET_PC.
- rdy_in=0 freezes everything, including redirects and updates presented that cycle; those are lost, and the sender must hold them.

## Configuration
- PC_PREDICT_BTB_EN defined: BTB, lookup and update logic as above.
- Not defined:
  - No BTB storage.
  - pred_taken_out is constant 0.
  - pred_target_out = pc_out+PC_STEP.
  - Update ports are ignored.
  - Redirect and stall behaviour is unchanged.

## Test plan
- Reset behaviour: assert rst_in between edges → pc_out=0 immediately. Release, then 3 free cycles → pc_out 4, 8, 12.
- Stall and redirect: stall_in=1 at pc=0x10 for 2 cycles → pc_out holds 0x10. Then redirect_in=1 to 0x200 while still stalled → pc_out=0x200 next cycle.
- Allocate and predict (BTB_EN):
  - Update pc=0x40, target=0x100, taken=1.
  - Later pc_out reaches 0x40 → pred_taken_out=1, pred_target_out=0x100, next pc_out=0x100.
- Counter hysteresis:
  - Entry at ctr=10, one not-taken update → ctr=01. pc 0x40 now predicts 0x44.
  - Two taken updates → ctr=11, predicts 0x100.
  - One not-taken update → ctr=10, still predicts 0x100.
- Alias and rdy: with BTB_DEPTH=16, pc 0x40+0x40=0x80 has the same index but a different tag → no hit; a taken update at 0x80 evicts 0x40. rdy_in=0 with redirect_in=1 → pc_out unchanged.
- Macro off: the same update at 0x40 → pred_taken_out stays 0, and pc_out steps 0x40→0x44.

Source files
------------

// File: rtl/pc_predict.sv
// pc_predict: fetch program-counter generator with optional branch target buffer.
// Each cycle it presents the fetch address with a next-PC prediction. It also accepts
// EX redirects and BTB training updates.
// Build option: define PC_PREDICT_BTB_EN to include the BTB. Without it, prediction is
// always sequential and the update port is ignored.
module pc_predict #(
    parameter int                ADDR_W    = 32,
    parameter int                BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_STEP   = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              stall_in,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_target_in,
    input  logic              update_valid_in,
    input  logic [ADDR_W-1:0] update_pc_in,
    input  logic [ADDR_W-1:0] update_target_in,
    input  logic              update_taken_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pred_taken_out,
    output logic [ADDR_W-1:0] pred_target_out
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] seq_pc;

    assign seq_pc = pc_q + ADDR_W'(PC_STEP);
    assign pc_out = pc_q;

`ifdef PC_PREDICT_BTB_EN
    localparam int IW    = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IW - 2;

    logic              valid_q [BTB_DEPTH];
    logic [TAG_W-1:0]  tag_q   [BTB_DEPTH];
    logic [ADDR_W-1:0] tgt_q   [BTB_DEPTH];
    logic [1:0]        ctr_q   [BTB_DEPTH];

    logic [IW-1:0]     rd_idx, up_idx;
    logic [TAG_W-1:0]  rd_tag, up_tag;
    logic              rd_hit, up_hit;
    logic              up_we;
    logic [1:0]        up_ctr_d;
    logic [ADDR_W-1:0] up_tgt_d;
    logic              unused_upd_lsb;

    // Byte-offset bits never take part in indexing or tagging.
    assign unused_upd_lsb = ^update_pc_in[1:0];

    assign rd_idx = pc_q[IW+1:2];
    assign rd_tag = pc_q[ADDR_W-1:IW+2];
    assign up_idx = update_pc_in[IW+1:2];
    assign up_tag = update_pc_in[ADDR_W-1:IW+2];

    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads the registered array, so a same-cycle update is only seen next cycle.
    assign pred_taken_out  = rd_hit & ctr_q[rd_idx][1];
    assign pred_target_out = pred_taken_out ? tgt_q[rd_idx] : seq_pc;

    // Compute the training write: counter step on hit, allocation on taken miss.
    always_comb begin
        up_we    = 1'b0;
        up_ctr_d = ctr_q[up_idx];
        up_tgt_d = tgt_q[up_idx];
        if (rdy_in && update_valid_in) begin
            if (up_hit) begin
                up_we = 1'b1;
                if (update_taken_in) begin
                    up_ctr_d = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
                    up_tgt_d = update_target_in;
                end else begin
                    up_ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
                end
            end else if (update_taken_in) begin
                up_we    = 1'b1;
                up_ctr_d = 2'b10;
                up_tgt_d = update_target_in;
            end
        end
    end

    // BTB storage: cleared on reset, one entry written per training update.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (up_we) begin
            valid_q[up_idx] <= 1'b1;
            tag_q[up_idx]   <= up_tag;
            tgt_q[up_idx]   <= up_tgt_d;
            ctr_q[up_idx]   <= up_ctr_d;
        end
    end
`else
    logic unused_update;

    assign unused_update = ^{update_valid_in, update_pc_in, update_target_in, update_taken_in};

    assign pred_taken_out  = 1'b0;
    assign pred_target_out = seq_pc;
`endif

    // Next fetch address: redirect beats stall, otherwise follow the prediction.
    always_comb begin
        pc_d = pc_q;
        if (rdy_in) begin
            if (redirect_in) begin
                pc_d = redirect_target_in;
            end else if (!stall_in) begin
                pc_d = pred_target_out;
            end
        end
    end

    // Fetch PC register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule
